// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store requester for a negedge-clocked byte-addressed data memory.
module load_store_unit #(
  parameter int MEM_AW      = 16,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [31:0]       req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [31:0]       resp_rdata_o,
  output logic              resp_err_o,
  output logic              mem_we_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [31:0]       mem_data_in_o,
  output logic [1:0]        mem_data_size_o,
  output logic              mem_signed_o,
  input  logic [31:0]       mem_data_out_i
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t              state_q;
  logic                mem_we_q, mem_signed_q, resp_valid_q, resp_err_q;
  logic [MEM_AW-1:0]   mem_addr_q;
  logic [31:0]         mem_data_in_q, resp_rdata_q;
  logic [1:0]          mem_data_size_q;
  logic                bad_range, bad_f3, bad_store, misalign, req_err;
  always_comb begin
    bad_range = (req_addr_i >> MEM_AW) != '0;
    bad_f3    = (req_funct3_i[1:0] == 2'b11) || (req_funct3_i[2] && req_funct3_i[1]);
    bad_store = req_we_i && req_funct3_i[2];
    misalign  = CHECK_ALIGN && ((req_funct3_i[1:0] == 2'b01 && req_addr_i[0]) ||
                                (req_funct3_i[1:0] == 2'b10 && req_addr_i[1:0] != 2'b00));
    req_err   = bad_range || bad_f3 || bad_store || misalign;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= IDLE;
      mem_we_q        <= 1'b0;
      mem_addr_q      <= '0;
      mem_data_in_q   <= '0;
      mem_data_size_q <= 2'b10;
      mem_signed_q    <= 1'b0;
      resp_valid_q    <= 1'b0;
      resp_rdata_q    <= '0;
      resp_err_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_valid_i) begin
          if (req_err) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= '0;
          end else begin
            state_q         <= ACCESS;
            mem_addr_q      <= req_addr_i[MEM_AW-1:0];
            mem_data_size_q <= req_funct3_i[1:0];
            mem_signed_q    <= ~req_funct3_i[2] && ~req_funct3_i[1];
            mem_data_in_q   <= req_we_i ? req_wdata_i : '0;
            mem_we_q        <= req_we_i;
          end
        end
        // memory has acted at the intervening negedge; mem_we_q still tells store from load
        ACCESS: begin
          state_q      <= RESP;
          resp_rdata_q <= mem_we_q ? '0 : mem_data_out_i;
          resp_err_q   <= 1'b0;
          resp_valid_q <= 1'b1;
          mem_we_q     <= 1'b0;
        end
        RESP: if (resp_ready_i) begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign req_ready_o     = state_q == IDLE;
  assign resp_valid_o    = resp_valid_q;
  assign resp_rdata_o    = resp_rdata_q;
  assign resp_err_o      = resp_err_q;
  assign mem_we_o        = mem_we_q;
  assign mem_addr_o      = mem_addr_q;
  assign mem_data_in_o   = mem_data_in_q;
  assign mem_data_size_o = mem_data_size_q;
  assign mem_signed_o    = mem_signed_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: random and directed requests against a byte-array memory model, with a negedge memory device.
module tb_load_store_unit;
  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        resp_valid, resp_ready = 1'b0, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_we, mem_signed;
  logic [15:0] mem_addr;
  logic [31:0] mem_data_in, mem_data_out = '0;
  logic [1:0]  mem_data_size;

  int n_chk = 0, n_fail = 0;
  logic [31:0] exp_rdata = '0;
  logic        exp_err = 1'b0;
  bit [7:0]    mem [65536];
  bit [7:0]    ref_mem [65536];

  load_store_unit #(.MEM_AW(16), .CHECK_ALIGN(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_we_i(req_we), .req_funct3_i(req_funct3), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
    .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_data_in_o(mem_data_in),
    .mem_data_size_o(mem_data_size), .mem_signed_o(mem_signed), .mem_data_out_i(mem_data_out));

  always #5 clk = ~clk;

  function automatic logic [31:0] dev_read(logic [15:0] a, logic [1:0] sz, logic sg);
    logic [31:0] w;
    w = {mem[a + 16'd3], mem[a + 16'd2], mem[a + 16'd1], mem[a]};
    return sz == 2'd0 ? {{24{sg & w[7]}}, w[7:0]} : sz == 2'd1 ? {{16{sg & w[15]}}, w[15:0]} : w;
  endfunction

  // memory device: writes and read data update at the negedge
  always @(negedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_data_in[7:0];
      if (mem_data_size != 2'd0) mem[mem_addr + 16'd1] <= mem_data_in[15:8];
      if (mem_data_size == 2'd2) begin
        mem[mem_addr + 16'd2] <= mem_data_in[23:16];
        mem[mem_addr + 16'd3] <= mem_data_in[31:24];
      end
    end
    mem_data_out <= dev_read(mem_addr, mem_data_size, mem_signed);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  function automatic bit ref_err(bit we, bit [2:0] f3, bit [31:0] a);
    bit legal;
    legal = f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5;
    return a[31:16] != 0 || !legal || (we && f3[2]) ||
           ((f3 == 3'd1 || f3 == 3'd5) && a[0]) || (f3 == 3'd2 && a[1:0] != 0);
  endfunction

  function automatic int nbytes(bit [2:0] f3);
    return f3[1:0] == 2'd0 ? 1 : f3[1:0] == 2'd1 ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(bit [15:0] a, bit [2:0] f3);
    int n;
    logic [31:0] v;
    n = nbytes(f3);
    v = 0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[16'(a + i)]) << (8 * i));
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  // compare process: response contents against the model, and no write while idle
  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      chk("resp_rdata", resp_rdata, exp_rdata);
      chk("resp_err", 32'(resp_err), 32'(exp_err));
      chk("req_ready_busy", 32'(req_ready), 0);
    end
    if (!rst && req_ready) chk("idle_mem_we", 32'(mem_we), 0);
  end

  task automatic do_req(input bit we, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd,
                        input int hold, output logic [31:0] rd, output logic e);
    int n;
    bit be;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) chk("ready_timeout", 32'(req_ready), 1);
    be = ref_err(we, f3, a);
    exp_err = be;
    exp_rdata = (be || we) ? 32'd0 : ref_load(a[15:0], f3);
    if (!be && we) for (int i = 0; i < nbytes(f3); i++) ref_mem[16'(a[15:0] + i)] = wd[8*i +: 8];
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_funct3 = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
    @(negedge clk);
    chk("lat_first_valid", 32'(resp_valid), 32'(be));
    chk("mem_we_pulse", 32'(mem_we), 32'(we && !be));
    if (!be) begin
      @(negedge clk);
      chk("lat_second_valid", 32'(resp_valid), 1);
      chk("mem_we_off", 32'(mem_we), 0);
    end
    rd = resp_rdata; e = resp_err;
    repeat (hold) @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    @(negedge clk);
    chk("resp_drop", 32'(resp_valid), 0);
    chk("ready_back", 32'(req_ready), 1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 1);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_data_in", mem_data_in, 0);
    chk("rst_mem_size", 32'(mem_data_size), 2);
    chk("rst_mem_signed", 32'(mem_signed), 0);
    chk("rst_resp_rdata", resp_rdata, 0);
    chk("rst_resp_err", 32'(resp_err), 0);

    do_req(1, 3'b010, 32'h10, 32'hDEADBEEF, 0, rd, e);
    do_req(0, 3'b010, 32'h10, 0, 0, rd, e);   chk("lw_deadbeef", rd, 32'hDEADBEEF);
    do_req(1, 3'b000, 32'h20, 32'h80, 0, rd, e);
    do_req(0, 3'b000, 32'h20, 0, 0, rd, e);   chk("lb_80", rd, 32'hFFFFFF80);
    do_req(0, 3'b100, 32'h20, 0, 0, rd, e);   chk("lbu_80", rd, 32'h00000080);
    do_req(0, 3'b101, 32'h20, 0, 0, rd, e);   chk("lhu_80", rd, 32'h00000080);
    do_req(0, 3'b010, 32'h22, 0, 0, rd, e);   chk("lw_misalign_err", 32'(e), 1); chk("lw_misalign_rd", rd, 0);
    do_req(0, 3'b001, 32'h21, 0, 0, rd, e);   chk("lh_misalign_err", 32'(e), 1);
    do_req(0, 3'b010, 32'h10000, 0, 0, rd, e); chk("range_err", 32'(e), 1);
    do_req(1, 3'b100, 32'h24, 32'h55, 0, rd, e); chk("store_bu_err", 32'(e), 1);
    do_req(0, 3'b010, 32'h10, 0, 5, rd, e);   chk("lw_after_err", rd, 32'hDEADBEEF); chk("lw_after_err_e", 32'(e), 0);

    do_req(1, 3'b010, 32'h30, 32'hAAAA5555, 0, rd, e);
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h30; req_wdata = 32'h12345678; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("abort_we_before", 32'(mem_we), 1);
    rst = 1'b1;
    #1;
    chk("abort_we_drop", 32'(mem_we), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", 32'(req_ready), 1);
    do_req(0, 3'b010, 32'h30, 0, 0, rd, e);   chk("abort_old_value", rd, 32'hAAAA5555);

    for (int k = 0; k < 300; k++) begin
      bit [31:0] a;
      a = ($urandom_range(0, 15) == 0) ? 32'hFFFC + $urandom_range(0, 3) : $urandom_range(0, 63);
      if ($urandom_range(0, 15) == 0) a = a | (32'h1 << $urandom_range(16, 31));
      do_req(1'($urandom), 3'($urandom), a, $urandom, $urandom_range(0, 2), rd, e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
